cdf_scan_controller: RTL and testbench

- Initiator side of the histogram-equalization divider interface. Walks the 256-bin histogram memory and finds cdf_min.
- Streams per-bin cumulative counts to the divider and collects the quotients.
- Writes the saturated 8-bit results into the pixel remapping LUT.
- Sits between the histogram accumulator (read side) and the remap stage (LUT write side).

---
 rtl/cdf_scan_controller_if.sv | 28 ++
 rtl/cdf_scan_controller.sv | 127 ++++++++++++
 tb/tb_cdf_scan_controller.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdf_scan_controller_if.sv
// Histogram read, divider and LUT write ports of the CDF scan controller.
// master = controller side, slave = memories/divider side.
interface cdf_scan_controller_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              hist_rd_en;
  logic [ADDR_W-1:0] hist_addr;
  logic [DATA_W-1:0] hist_rdata;
  logic [DATA_W-1:0] cdf_in;
  logic [DATA_W-1:0] cdf_min;
  logic              div_en;
  logic [DATA_W-1:0] g_out;
  logic              ready_g_out;
  logic              lut_we;
  logic [ADDR_W-1:0] lut_addr;
  logic [7:0]        lut_wdata;

  modport master (
    output hist_rd_en, hist_addr, cdf_in, cdf_min, div_en, lut_we, lut_addr, lut_wdata,
    input  hist_rdata, g_out, ready_g_out
  );

  modport slave (
    input  hist_rd_en, hist_addr, cdf_in, cdf_min, div_en, lut_we, lut_addr, lut_wdata,
    output hist_rdata, g_out, ready_g_out
  );
endinterface

// File: rtl/cdf_scan_controller.sv
// Histogram-equalisation scan: finds cdf_min, streams cumulative counts to the
// divider one bin at a time and writes saturated quotients into the remap LUT.
module cdf_scan_controller #(
  parameter int BINS   = 256,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  cdf_scan_controller_if.master bus,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [3:0] {
    IDLE, MIN_RD, MIN_CHK, SCAN_RD, SCAN_ACC, DIV_SETUP,
    DIV_GO, DIV_WAIT, WRITE, ZERO_FILL, DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(BINS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] cdf_min_q, cdf_min_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [DATA_W-1:0] acc_sum;
  logic [7:0]        g_sat;

  assign acc_sum = acc_q + bus.hist_rdata;
  assign g_sat   = (|bus.g_out[DATA_W-1:8]) ? 8'hFF : bus.g_out[7:0];

  // The accumulator register doubles as the divider operand, so it is
  // naturally stable from DIV_SETUP until the next bin is read.
  assign bus.cdf_in  = acc_q;
  assign bus.cdf_min = cdf_min_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      cdf_min_q <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      cdf_min_q <= cdf_min_d;
      wdata_q   <= wdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    cdf_min_d = cdf_min_q;
    wdata_d   = wdata_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = MIN_RD;
          idx_d     = '0;
          acc_d     = '0;
          cdf_min_d = '0;
        end
      end
      MIN_RD:  state_d = MIN_CHK;
      MIN_CHK: begin
        if (bus.hist_rdata != '0) begin
          cdf_min_d = bus.hist_rdata;
          idx_d     = '0;
          state_d   = SCAN_RD;
        end else if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ZERO_FILL;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = MIN_RD;
        end
      end
      SCAN_RD: state_d = SCAN_ACC;
      SCAN_ACC: begin
        acc_d = acc_sum;
        // Leading empty bins map to 0 without a divide.
        if (acc_sum == '0) begin
          wdata_d = '0;
          state_d = WRITE;
        end else begin
          state_d = DIV_SETUP;
        end
      end
      DIV_SETUP: state_d = DIV_GO;
      DIV_GO:    state_d = DIV_WAIT;
      DIV_WAIT: begin
        if (bus.ready_g_out) begin
          wdata_d = g_sat;
          state_d = WRITE;
        end
      end
      WRITE, ZERO_FILL: begin
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = (state_q == WRITE) ? SCAN_RD : ZERO_FILL;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.hist_rd_en = (state_q == MIN_RD) || (state_q == SCAN_RD);
    bus.hist_addr  = bus.hist_rd_en ? idx_q : '0;
    bus.div_en     = (state_q == DIV_GO);
    bus.lut_we     = (state_q == WRITE) || (state_q == ZERO_FILL);
    bus.lut_addr   = bus.lut_we ? idx_q : '0;
    bus.lut_wdata  = (state_q == WRITE) ? wdata_q : 8'h00;
    busy           = (state_q != IDLE);
    done           = (state_q == DONE);
  end

endmodule

// File: tb/tb_cdf_scan_controller.sv
// Bench for cdf_scan_controller: histogram RAM and divider models, LUT-write
// scoreboard fed from a reference equalisation computed per scan.
module tb_cdf_scan_controller;

  localparam int  SIZE   = 1600;
  localparam int  BUDGET = 20000;

  logic clk;
  logic reset;
  logic start;
  logic busy;
  logic done;

  cdf_scan_controller_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  cdf_scan_controller #(.BINS(256), .ADDR_W(8), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] hist [256];
  logic [15:0] exp_q [$];
  int          exp_divs;
  logic [31:0] exp_min;

  int cyc = 0;
  int wr_cnt, done_cnt, div_cnt, stable_err;
  int first_wr_cyc, last_wr_cyc, done_cyc;
  int ovr_idx = 0;
  int rand_lat = 0;
  int fixed_lat = 0;
  int spur_arm = 0;
  int spur_done = 0;
  int div_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Histogram RAM: one-cycle read latency; data is valid for exactly that cycle.
  always @(posedge clk) begin
    if (bus.hist_rd_en === 1'b1) bus.hist_rdata <= hist[bus.hist_addr];
    else                         bus.hist_rdata <= 32'hDEAD_BEEF;
  end

  function automatic longint div_model(longint cdf, longint mn);
    if (mn == SIZE) return 255;
    return (cdf - mn) * 255 / (SIZE - mn);
  endfunction

  // Divider: latches operands on div_en, answers after 1..40 cycles.
  int          div_pend = 0;
  int          div_wait = 0;
  int          lat_n = 0;
  logic [31:0] lat_cdf, lat_min;
  always @(negedge clk) begin
    bus.ready_g_out = 1'b0;
    if (reset || !busy) begin
      div_pend = 0;
      if (reset) bus.g_out = '0;
    end else if (div_pend != 0) begin
      if (bus.cdf_in !== lat_cdf || bus.cdf_min !== lat_min) stable_err++;
      if (div_wait == 0) begin
        bus.g_out       = (lat_n == ovr_idx) ? 32'd300 : 32'(div_model(lat_cdf, lat_min));
        bus.ready_g_out = 1'b1;
        div_pend        = 0;
      end else begin
        div_wait--;
      end
    end else if (spur_arm != 0 && div_seen != 0 && bus.hist_rd_en === 1'b1) begin
      bus.g_out       = 32'd7;
      bus.ready_g_out = 1'b1;
      spur_arm        = 0;
      spur_done       = 1;
    end
    if (bus.div_en === 1'b1) begin
      div_cnt++;
      div_seen = 1;
      div_pend = 1;
      lat_n    = div_cnt;
      lat_cdf  = bus.cdf_in;
      lat_min  = bus.cdf_min;
      div_wait = (rand_lat != 0) ? int'($urandom_range(39, 0)) : fixed_lat;
    end
  end

  // LUT-write scoreboard.
  always @(negedge clk) begin
    if (bus.lut_we === 1'b1) begin
      logic [15:0] e;
      if (wr_cnt == 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      wr_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $error("FAIL lut_unexpected_write addr=%0d data=%0d required=no write",
               bus.lut_addr, bus.lut_wdata);
      end else begin
        e = exp_q.pop_front();
        assert ({bus.lut_addr, bus.lut_wdata} === e) else begin
          failures++;
          $error("FAIL lut_write got addr=%0d data=%0d required addr=%0d data=%0d",
                 bus.lut_addr, bus.lut_wdata, e[15:8], e[7:0]);
        end
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d required=%0d", tag, got, exp);
    end
  endtask

  task automatic build_exp();
    logic [31:0] acc = '0;
    logic [31:0] mn = '0;
    int          nd = 0;
    longint      g;
    logic [7:0]  v;
    for (int i = 0; i < 256; i++)
      if (mn == 0 && hist[i] != 0) mn = hist[i];
    exp_min = mn;
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      acc = acc + hist[i];
      if (mn == 0 || acc == 0) begin
        v = 8'd0;
      end else begin
        nd++;
        g = (nd == ovr_idx) ? 300 : div_model(acc, mn);
        v = (g > 255) ? 8'd255 : 8'(g);
      end
      exp_q.push_back({8'(i), v});
    end
    exp_divs = nd;
  endtask

  task automatic load_hist(input int b0, input int v0, input int b1, input int v1,
                           input int b2, input int v2);
    for (int i = 0; i < 256; i++) hist[i] = '0;
    if (b0 >= 0) hist[b0] = 32'(v0);
    if (b1 >= 0) hist[b1] = 32'(v1);
    if (b2 >= 0) hist[b2] = 32'(v2);
  endtask

  task automatic clear_counters();
    wr_cnt = 0; done_cnt = 0; div_cnt = 0; stable_err = 0;
    first_wr_cyc = 0; last_wr_cyc = 0; done_cyc = 0;
    div_seen = 0; spur_done = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_hist_rd_en"}, 64'(bus.hist_rd_en), 64'd0);
    chk({tag, "_hist_addr"},  64'(bus.hist_addr),  64'd0);
    chk({tag, "_cdf_in"},     64'(bus.cdf_in),     64'd0);
    chk({tag, "_cdf_min"},    64'(bus.cdf_min),    64'd0);
    chk({tag, "_div_en"},     64'(bus.div_en),     64'd0);
    chk({tag, "_lut_we"},     64'(bus.lut_we),     64'd0);
    chk({tag, "_lut_addr"},   64'(bus.lut_addr),   64'd0);
    chk({tag, "_lut_wdata"},  64'(bus.lut_wdata),  64'd0);
    chk({tag, "_busy"},       64'(busy),           64'd0);
    chk({tag, "_done"},       64'(done),           64'd0);
  endtask

  // One full scan against the reference; restart_at>0 re-pulses start mid-scan.
  task automatic run_scan(input string tag, input int restart_at);
    int n = 0;
    clear_counters();
    build_exp();
    pulse_start();
    chk({tag, "_busy_after_start"}, 64'(busy), 64'd1);
    if (restart_at > 0) begin
      repeat (restart_at) @(negedge clk);
      chk({tag, "_busy_at_restart"}, 64'(busy), 64'd1);
      pulse_start();
    end
    while (done_cnt == 0 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (done_cnt != 0) else begin
      failures++;
      $error("FAIL %s_timeout done pulses=%0d required=1", tag, done_cnt);
    end
    repeat (20) @(negedge clk);
    chk({tag, "_writes"},       64'(wr_cnt),      64'd256);
    chk({tag, "_left_in_sb"},   64'(exp_q.size()), 64'd0);
    chk({tag, "_done_pulses"},  64'(done_cnt),    64'd1);
    chk({tag, "_div_en_count"}, 64'(div_cnt),     64'(exp_divs));
    chk({tag, "_cdf_min"},      64'(bus.cdf_min), 64'(exp_min));
    chk({tag, "_done_after_last_write"}, 64'(done_cyc - last_wr_cyc), 64'd1);
    chk({tag, "_operand_unstable"}, 64'(stable_err), 64'd0);
    chk({tag, "_busy_end"},     64'(busy),        64'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 256; i++) hist[i] = '0;
    clear_counters();
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: three populated bins, cdf_min=400, lut = 0, 85, 255...
    load_hist(0, 400, 1, 400, 2, 800);
    run_scan("s1_basic", 0);

    // 2: leading empty bins bypass the divider
    load_hist(10, 100, 20, 1500, -1, 0);
    run_scan("s2_sparse", 0);

    // 3: empty histogram -> zero fill without any divide
    load_hist(-1, 0, -1, 0, -1, 0);
    run_scan("s3_zero", 0);
    chk("s3_consecutive_span", 64'(last_wr_cyc - first_wr_cyc), 64'd255);

    // 4: random divider latency plus a stray ready during SCAN_RD
    load_hist(0, 400, 1, 400, 2, 800);
    rand_lat = 1;
    spur_arm = 1;
    run_scan("s4_random_lat", 0);
    chk("s4_spurious_ready_sent", 64'(spur_done), 64'd1);
    rand_lat = 0;
    spur_arm = 0;

    // 5: reset while waiting on the divider for bin 50
    clear_counters();
    build_exp();
    fixed_lat = 10;
    pulse_start();
    n = 0;
    while (wr_cnt < 50 && n < BUDGET) begin @(negedge clk); n++; end
    while (bus.div_en !== 1'b1 && n < BUDGET) begin @(negedge clk); n++; end
    chk("s5_reached_bin50", 64'(wr_cnt), 64'd50);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle_zero("s5_after_reset");
    exp_q.delete();
    repeat (60) @(negedge clk);
    chk("s5_no_write_after_reset", 64'(wr_cnt), 64'd50);
    chk("s5_no_done", 64'(done_cnt), 64'd0);
    fixed_lat = 0;
    run_scan("s5_rescan", 0);

    // 6: second start mid-scan is ignored; quotient 300 saturates
    ovr_idx = 2;
    run_scan("s6_restart_sat", 100);
    ovr_idx = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
